// File: rtl/dc_sync_filter_hyper.sv
// dc_sync_filter_hyper: multi-bit synchroniser for asynchronous level inputs.
// Each channel has a flop chain, a stability filter, and registered rise/fall
// pulses. Channels are independent, so each one is a lane instance in a
// generate array.

// Per-channel lane: sync chain -> stability filter -> edge pulses.
module dc_sync_filter_hyper_lane #(
  parameter int unsigned STAGES        = 2,
  parameter int unsigned FILTER_CYCLES = 1,
  parameter logic        RST_BIT       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic d_out,
  output logic rise_o,
  output logic fall_o
);

  // Counter must hold FILTER_CYCLES-1, never narrower than one bit.
  localparam int unsigned CW_RAW = $clog2(FILTER_CYCLES + 1);
  localparam int unsigned CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

  logic [STAGES-1:0] r_stage;
  logic [CW-1:0]     r_cnt;
  logic              r_out;
  logic              r_rise;
  logic              r_fall;

  logic              w_s;
  logic              w_diff;
  logic              w_take;

  // Synchronised level is the last flop of the chain.
  assign w_s    = r_stage[STAGES-1];
  assign w_diff = (w_s != r_out);
  assign w_take = w_diff && (r_cnt == CNT_MAX);

  // Plain flop chain; nothing sits between stages so metastability can settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_stage <= {STAGES{RST_BIT}};
    else     r_stage <= {r_stage[STAGES-2:0], d_in};
  end

  // Stability filter: the output only follows after FILTER_CYCLES
  // consecutive cycles of disagreement; any agreement clears the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_out <= RST_BIT;
    end else if (!w_diff) begin
      r_cnt <= '0;
    end else if (w_take) begin
      r_out <= w_s;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Edge pulses are registered on the same edge that updates the output,
  // so they line up with the first cycle showing the new level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_take &&  w_s;
      r_fall <= w_take && !w_s;
    end
  end

  assign d_out  = r_out;
  assign rise_o = r_rise;
  assign fall_o = r_fall;

endmodule

// Top: parameter checks plus one lane per channel.
module dc_sync_filter_hyper #(
  parameter int unsigned     WIDTH         = 1,
  parameter int unsigned     STAGES        = 2,
  parameter int unsigned     FILTER_CYCLES = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  // A single flop is not a synchroniser, and a zero-cycle filter is meaningless.
  generate
    if (STAGES < 2) begin : g_bad_stages
      $error("dc_sync_filter_hyper: STAGES must be >= 2");
    end
    if (FILTER_CYCLES < 1) begin : g_bad_filter
      $error("dc_sync_filter_hyper: FILTER_CYCLES must be >= 1");
    end
    if (WIDTH < 1) begin : g_bad_width
      $error("dc_sync_filter_hyper: WIDTH must be >= 1");
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      dc_sync_filter_hyper_lane #(
        .STAGES        (STAGES),
        .FILTER_CYCLES (FILTER_CYCLES),
        .RST_BIT       (RESET_VALUE[gi])
      ) u_lane (
        .clk    (clk),
        .rst    (rst),
        .d_in   (d_in[gi]),
        .d_out  (d_out[gi]),
        .rise_o (rise_o[gi]),
        .fall_o (fall_o[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_dc_sync_filter_hyper.sv
// Scoreboard bench: instance A (W=4,S=2,F=3) and instance B (W=1,S=3,F=1).
// A reference model pushes expected outputs each edge; a monitor pops and
// compares shortly after the edge.
module tb_dc_sync_filter_hyper;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a_in = 4'hF;
  logic [3:0] a_out, a_rise, a_fall;
  logic       b_in = 1'b0;
  logic       b_out, b_rise, b_fall;

  int tests = 0;
  int fails = 0;
  bit done  = 1'b0;

  always #5 clk = ~clk;

  dc_sync_filter_hyper #(.WIDTH(4), .STAGES(2), .FILTER_CYCLES(3), .RESET_VALUE(4'b0000)) u_a (
    .clk(clk), .rst(rst), .d_in(a_in), .d_out(a_out), .rise_o(a_rise), .fall_o(a_fall));

  dc_sync_filter_hyper #(.WIDTH(1), .STAGES(3), .FILTER_CYCLES(1), .RESET_VALUE(1'b0)) u_b (
    .clk(clk), .rst(rst), .d_in(b_in), .d_out(b_out), .rise_o(b_rise), .fall_o(b_fall));

  typedef struct packed { logic [3:0] o; logic [3:0] r; logic [3:0] f; } exp_t;
  exp_t q_a[$];
  exp_t q_b[$];

  // Reference model state: history of sampled inputs indexed by edge number
  // since reset; the synchronised value seen at edge n is the sample from
  // edge n-STAGES.
  logic [3:0] m_out  [2];
  int         m_run  [2][4];
  logic [3:0] m_hist [2][8];
  int         m_n    [2];

  task automatic model_step(input int id, input logic [3:0] din, input int st,
                            input int fc, input int w, input logic r, output exp_t e);
    logic [3:0] sp;
    e = '0;
    if (r) begin
      m_out[id] = 4'h0;
      m_n[id]   = 0;
      for (int b = 0; b < 4; b++) m_run[id][b] = 0;
    end else begin
      sp = (m_n[id] >= st) ? m_hist[id][(m_n[id] - st) % 8] : 4'h0;
      m_hist[id][m_n[id] % 8] = din;
      m_n[id]++;
      for (int b = 0; b < w; b++) begin
        if (sp[b] != m_out[id][b]) begin
          m_run[id][b]++;
          if (m_run[id][b] == fc) begin
            m_out[id][b] = sp[b];
            if (sp[b]) e.r[b] = 1'b1;
            else       e.f[b] = 1'b1;
            m_run[id][b] = 0;
          end
        end else begin
          m_run[id][b] = 0;
        end
      end
    end
    e.o = m_out[id];
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: compute the expected post-edge outputs from the inputs at the edge.
  always @(posedge clk) begin
    exp_t e;
    if (!done) begin
      model_step(0, a_in, 2, 3, 4, rst, e);
      q_a.push_back(e);
      model_step(1, {3'b000, b_in}, 3, 1, 1, rst, e);
      q_b.push_back(e);
    end
  end

  // Monitor: compare DUT outputs against the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    if (!done) begin
      #1;
      if (q_a.size() == 0 || q_b.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        e = q_a.pop_front();
        chk("a_dout", a_out, e.o);
        chk("a_rise", a_rise, e.r);
        chk("a_fall", a_fall, e.f);
        chk("a_excl", a_rise & a_fall, 4'h0);
        e = q_b.pop_front();
        chk("b_dout", {3'b000, b_out}, e.o);
        chk("b_rise", {3'b000, b_rise}, e.r);
        chk("b_fall", {3'b000, b_fall}, e.f);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stimulus: directed scenarios, then randomized runs.
  initial begin
    int len;
    logic [3:0] v;
    // Reset held with all inputs high.
    rst = 1'b1; a_in = 4'hF; b_in = 1'b1;
    cyc(4);
    rst = 1'b0;
    cyc(1);
    a_in = 4'h0; b_in = 1'b0;
    cyc(10);
    // Latency on bit 0.
    a_in = 4'h1; b_in = 1'b1;
    cyc(8);
    a_in = 4'h0; b_in = 1'b0;
    cyc(8);
    // Glitch of 2 cycles is rejected, 3 cycles passes.
    a_in = 4'h2; cyc(2); a_in = 4'h0; cyc(8);
    a_in = 4'h2; cyc(3); a_in = 4'h0; cyc(10);
    // Simultaneous channels.
    a_in = 4'hA; cyc(8);
    a_in = 4'h5; cyc(8);
    a_in = 4'h0; cyc(8);
    // Reset in the middle of a pending transition on bit 2.
    a_in = 4'h4; b_in = 1'b1;
    cyc(4);
    rst = 1'b1;
    #1;
    chk("async_rst_dout", a_out, 4'h0);
    chk("async_rst_pulse", a_rise | a_fall, 4'h0);
    cyc(1);
    rst = 1'b0;
    cyc(8);
    // Input toggling faster than the filter keeps the output frozen.
    for (int i = 0; i < 12; i++) begin
      a_in = (i % 2 == 0) ? 4'h0 : 4'hF;
      cyc(1);
    end
    cyc(8);
    // Randomized runs of varying length per step.
    for (int i = 0; i < 150; i++) begin
      v    = 4'($urandom);
      len  = $urandom_range(1, 5);
      a_in = v;
      b_in = 1'($urandom);
      cyc(len);
      if ($urandom_range(0, 40) == 0) begin
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
      end
    end
    cyc(10);
    done = 1'b1;
    #20;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dc_sync_filter_hyper.md
Name: dc_sync_filter_hyper

Overview:
- Parametrised multi-bit synchroniser for asynchronous control/status inputs entering the uDMA HyperBus clock domain (e.g. RWDS-derived flags, pad-level status, cross-domain level flags).
- Each channel passes through a configurable-depth flop chain, then an optional per-channel stability (glitch) filter.
- Registered rise/fall pulses are produced per channel so downstream FSMs need no separate edge detectors.

Parameters:
- WIDTH, 1, number of independent single-bit channels.
- STAGES, 2, synchroniser flop depth per channel; must be >= 2, otherwise elaboration error.
- FILTER_CYCLES, 1, consecutive stable cycles required before d_out follows; must be >= 1, otherwise elaboration error. 1 = no filtering (one extra register).
- RESET_VALUE, 'h0, reset value of every sync stage and of d_out, per bit.

Ports:
- clk  input  1  block clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- d_in  input  WIDTH  asynchronous inputs, one per channel.
- d_out  output  WIDTH  synchronised, filtered level per channel.
- rise_o  output  WIDTH  one-cycle pulse: d_out bit went 0->1.
- fall_o  output  WIDTH  one-cycle pulse: d_out bit went 1->0.

Interface (already decided):
- One clock, clk.
- Reset rst is asynchronous and active-high.

Behaviour:
- Reset (rst=1, asynchronous assert):
  - all sync stages and d_out = RESET_VALUE;
  - all filter counters = 0;
  - rise_o = fall_o = 0.
- Reset release: no rise/fall pulse from RESET_VALUE itself. Deassertion is assumed synchronised externally.
- Sync chain, per bit i:
  - stage[0] <= d_in[i]; stage[n] <= stage[n-1].
  - s[i] = stage[STAGES-1].
  - No logic between stages.
- Filter, per bit i, with counter cnt[i] of width $clog2(FILTER_CYCLES+1), min 1. Each cycle:
  - if s[i] == d_out[i]: cnt <= 0.
  - else if cnt == FILTER_CYCLES-1: d_out[i] <= s[i], cnt <= 0.
  - else: cnt <= cnt+1.
- Edge pulses:
  - rise_o[i] is registered. It is 1 exactly in the cycle in which d_out[i] first shows the new value 1; otherwise 0.
  - fall_o[i] is the same for the new value 0.
  - rise_o[i] and fall_o[i] are never both 1.
- Latency: a d_in change sampled at edge k appears on d_out (and pulses) after edge k + STAGES - 1 + FILTER_CYCLES. For STAGES=2, FILTER_CYCLES=1 this is edge k+2.
- Glitch rejection: a change of s lasting fewer than FILTER_CYCLES consecutive cycles never reaches d_out. A return to the old value clears the counter.
- Exactly FILTER_CYCLES stable cycles is sufficient (boundary passes).
- Channels are fully independent. Simultaneous changes on several bits each follow their own counters, and multiple rise/fall bits may be set in one cycle.
- Toggling input faster than FILTER_CYCLES keeps d_out frozen indefinitely. This is required behaviour, not a fault.
- Reset mid-filter: counters clear immediately, d_out returns to RESET_VALUE, and any pending transition is discarded.
- No combinational path from d_in to any output.

Test Plan:
- Bench parameters: WIDTH=4, STAGES=2, FILTER_CYCLES=3, RESET_VALUE=4'b0000.
- Reset: hold rst=1 with d_in=4'hF, then release -> d_out=0, rise_o=fall_o=0 during reset and in the first cycle after release.
- Latency: after reset with d_in=0, set d_in[0]=1 before edge 0 and hold -> d_out[0]=1 after edge 4; rise_o[0]=1 for exactly that one cycle; d_out[3:1] stay 0.
- Glitch rejection: from settled 0, pulse d_in[1]=1 for 2 cycles -> d_out[1] stays 0, no rise_o[1]. Then pulse for exactly 3 cycles -> d_out[1] goes 1 with one rise_o[1] pulse, then returns 0 with one fall_o[1] pulse.
- Simultaneous channels: from settled 0, set d_in to 4'hA (0->1 on bits 1 and 3) -> rise_o=4'hA in one cycle after edge 4. Then set d_in to 4'h5 -> rise_o=4'h5 and fall_o=4'hA in the same cycle.
- Reset mid-filter: raise d_in[2] and assert rst after 2 of the 3 filter cycles; release after 1 cycle with d_in[2] still 1 -> no pulse during reset; d_out[2] rises only after full sync+filter latency from release, i.e. 4 edges.
- Parameter sweep: STAGES=3, FILTER_CYCLES=1, WIDTH=1 -> d_out follows d_in after edge k+3 with one-cycle pulses. STAGES=1 or FILTER_CYCLES=0 -> elaboration fails.
